// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: queues key press/release events from debounced
// key levels and maps each sounding key onto a synth channel ("voice"). When
// every voice is busy, the oldest one is stolen.
// Ports:
//   clk, rst (async, active-low)
//   key_down     - held level per key
//   key_pitches  - pitch word per key, key i at [i*PITCH_W +: PITCH_W]
//   voice_pitch  - registered pitch per voice, same packing
//   voice_ena    - registered enable per voice
//   voice_key    - 4-bit owning key index per voice
//   steal_pulse  - one-cycle pulse when a busy voice is reassigned
module voice_allocator #(
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned PITCH_W    = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_down,
  input  logic [NUM_KEYS*PITCH_W-1:0]   key_pitches,
  output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
  output logic [NUM_VOICES-1:0]         voice_ena,
  output logic [NUM_VOICES*4-1:0]       voice_key,
  output logic                          steal_pulse
);

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned RANK_W = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0] key_prev, press_pend, rel_pend;
  logic [RANK_W-1:0]   age_q [NUM_VOICES];

  logic [NUM_KEYS-1:0]           press_edge, rel_edge, press_pend_n, rel_pend_n;
  logic                          rel_any, press_any;
  logic [KEY_W-1:0]              rel_key, press_key;
  logic [PITCH_W-1:0]            sel_pitch;
  logic [NUM_VOICES-1:0]         owner_sel, free_sel, oldest_sel, alloc_sel;
  logic                          free_hit;
  logic [RANK_W-1:0]             alloc_rank;
  logic [NUM_VOICES*PITCH_W-1:0] voice_pitch_n;
  logic [NUM_VOICES-1:0]         voice_ena_n;
  logic [NUM_VOICES*KEY_W-1:0]   voice_key_n;
  logic                          steal_n;
  logic [RANK_W-1:0]             age_n [NUM_VOICES];

  // Event selection, voice selection and next-state computation.
  always_comb begin
    press_edge = key_down & ~key_prev;
    rel_edge   = ~key_down & key_prev;
    rel_any    = |rel_pend;
    press_any  = |press_pend;

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    rel_key   = '0;
    press_key = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (rel_pend[i])   rel_key   = KEY_W'(i);
      if (press_pend[i]) press_key = KEY_W'(i);
    end

    sel_pitch = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (press_key == KEY_W'(i)) sel_pitch = key_pitches[i*PITCH_W +: PITCH_W];
    end

    // One-hot voice picks: owner of the released key, lowest free, oldest.
    owner_sel  = '0;
    free_sel   = '0;
    oldest_sel = '0;
    free_hit   = 1'b0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (voice_ena[v] && (voice_key[v*KEY_W +: KEY_W] == rel_key) && (owner_sel == '0))
        owner_sel[v] = 1'b1;
      if (!voice_ena[v] && !free_hit) begin
        free_sel[v] = 1'b1;
        free_hit    = 1'b1;
      end
      if (age_q[v] == '0) oldest_sel[v] = 1'b1;
    end
    alloc_sel = free_hit ? free_sel : oldest_sel;

    alloc_rank = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (alloc_sel[v]) alloc_rank = age_q[v];
    end

    press_pend_n  = press_pend;
    rel_pend_n    = rel_pend;
    voice_pitch_n = voice_pitch;
    voice_ena_n   = voice_ena;
    voice_key_n   = voice_key;
    steal_n       = 1'b0;
    age_n         = age_q;

    if (rel_any) begin
      rel_pend_n  = rel_pend & ~(NUM_KEYS'(1) << rel_key);
      voice_ena_n = voice_ena & ~owner_sel;
    end else if (press_any) begin
      press_pend_n = press_pend & ~(NUM_KEYS'(1) << press_key);
      steal_n      = ~free_hit;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        if (alloc_sel[v]) begin
          voice_ena_n[v]                      = 1'b1;
          voice_pitch_n[v*PITCH_W +: PITCH_W] = sel_pitch;
          voice_key_n[v*KEY_W +: KEY_W]       = press_key;
          age_n[v]                            = RANK_W'(NUM_VOICES - 1);
        end else if (age_q[v] > alloc_rank) begin
          age_n[v] = age_q[v] - RANK_W'(1);
        end
      end
    end

    // New edges land after service, so a press being served this cycle is
    // no longer "still pending" and its release must be queued.
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (press_edge[i]) press_pend_n[i] = 1'b1;
      if (rel_edge[i]) begin
        if (press_pend_n[i]) press_pend_n[i] = 1'b0;
        else                 rel_pend_n[i]   = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev    <= '0;
      press_pend  <= '0;
      rel_pend    <= '0;
      voice_pitch <= '0;
      voice_ena   <= '0;
      voice_key   <= '0;
      steal_pulse <= 1'b0;
      for (int v = 0; v < int'(NUM_VOICES); v++) age_q[v] <= RANK_W'(v);
    end else begin
      key_prev    <= key_down;
      press_pend  <= press_pend_n;
      rel_pend    <= rel_pend_n;
      voice_pitch <= voice_pitch_n;
      voice_ena   <= voice_ena_n;
      voice_key   <= voice_key_n;
      steal_pulse <= steal_n;
      age_q       <= age_n;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, async reset
// sequence, then randomized key activity against a queue-based model.
module tb_voice_allocator;

  localparam int unsigned NK = 8;
  localparam int unsigned NV = 2;
  localparam int unsigned PW = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NK-1:0]     key_down;
  logic [NK*PW-1:0]  key_pitches;
  logic [NV*PW-1:0]  voice_pitch;
  logic [NV-1:0]     voice_ena;
  logic [NV*4-1:0]   voice_key;
  logic              steal_pulse;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .PITCH_W(PW)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .key_pitches(key_pitches),
    .voice_pitch(voice_pitch), .voice_ena(voice_ena), .voice_key(voice_key),
    .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_exp(input logic [1:0] ena, input int p0, input int p1,
                                           input int k0, input int k1, input logic st);
    return 64'({st, 4'(k1), 4'(k0), ena, 12'(p1), 12'(p0)});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({steal_pulse, voice_key, voice_ena, voice_pitch});
  endfunction

  // Behavioural model: pending events as flag arrays, age as a queue of
  // voice numbers ordered oldest first.
  bit m_prev [NK];
  bit m_pp   [NK];
  bit m_rp   [NK];
  bit m_ena  [NV];
  int m_pitch[NV];
  int m_key  [NV];
  bit m_steal;
  int age_order[$];

  task automatic model_reset();
    for (int i = 0; i < int'(NK); i++) begin
      m_prev[i] = 0; m_pp[i] = 0; m_rp[i] = 0;
    end
    for (int v = 0; v < int'(NV); v++) begin
      m_ena[v] = 0; m_pitch[v] = 0; m_key[v] = 0;
    end
    m_steal = 0;
    age_order = {};
    for (int v = 0; v < int'(NV); v++) age_order.push_back(v);
  endtask

  task automatic model_step(input logic [NK-1:0] kd, input logic [NK*PW-1:0] kp);
    int r, p, v;
    r = -1; p = -1; v = -1;
    m_steal = 0;
    for (int i = 0; i < int'(NK); i++) if (m_rp[i] && r < 0) r = i;
    for (int i = 0; i < int'(NK); i++) if (m_pp[i] && p < 0) p = i;
    if (r >= 0) begin
      m_rp[r] = 0;
      for (int j = 0; j < int'(NV); j++) if (m_ena[j] && m_key[j] == r && v < 0) v = j;
      if (v >= 0) m_ena[v] = 0;
    end else if (p >= 0) begin
      m_pp[p] = 0;
      for (int j = 0; j < int'(NV); j++) if (!m_ena[j] && v < 0) v = j;
      if (v < 0) begin
        v = age_order[0];
        m_steal = 1;
      end
      m_ena[v]   = 1;
      m_pitch[v] = int'(kp[p*PW +: PW]);
      m_key[v]   = p;
      for (int j = 0; j < age_order.size(); j++) begin
        if (age_order[j] == v) begin
          age_order.delete(j);
          break;
        end
      end
      age_order.push_back(v);
    end
    for (int i = 0; i < int'(NK); i++) begin
      if (kd[i] && !m_prev[i]) m_pp[i] = 1;
      if (!kd[i] && m_prev[i]) begin
        if (m_pp[i]) m_pp[i] = 0;
        else         m_rp[i] = 1;
      end
      m_prev[i] = kd[i];
    end
  endtask

  function automatic logic [63:0] model_vec();
    return pack_exp({m_ena[1], m_ena[0]}, m_pitch[0], m_pitch[1], m_key[0], m_key[1], m_steal);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step(key_down, key_pitches);
    #1;
  endtask

  typedef struct {
    logic [7:0] kd;
    logic [1:0] ena;
    int         p0, p1, k0, k1;
    logic       st;
  } vec_t;

  vec_t tbl[$];
  int   pv[NK] = '{10, 99, 178, 44, 77, 52, 66, 35};

  initial begin
    rst = 1'b1;
    key_down = '0;
    for (int i = 0; i < int'(NK); i++) key_pitches[i*PW +: PW] = 12'(pv[i]);

    // key 2 press and release
    tbl.push_back('{8'h04, 2'b00,   0,  0, 0, 0, 1'b0});
    tbl.push_back('{8'h04, 2'b01, 178,  0, 2, 0, 1'b0});
    tbl.push_back('{8'h00, 2'b01, 178,  0, 2, 0, 1'b0});
    tbl.push_back('{8'h00, 2'b00, 178,  0, 2, 0, 1'b0});
    // keys 3 and 5 together
    tbl.push_back('{8'h28, 2'b00, 178,  0, 2, 0, 1'b0});
    tbl.push_back('{8'h28, 2'b01,  44,  0, 3, 0, 1'b0});
    tbl.push_back('{8'h28, 2'b11,  44, 52, 3, 5, 1'b0});
    // key 7 steals voice 0
    tbl.push_back('{8'hA8, 2'b11,  44, 52, 3, 5, 1'b0});
    tbl.push_back('{8'hA8, 2'b11,  35, 52, 7, 5, 1'b1});
    tbl.push_back('{8'hA8, 2'b11,  35, 52, 7, 5, 1'b0});
    // release stolen key 3 while key 4 blips for one cycle
    tbl.push_back('{8'hB0, 2'b11,  35, 52, 7, 5, 1'b0});
    tbl.push_back('{8'hA0, 2'b11,  35, 52, 7, 5, 1'b0});
    tbl.push_back('{8'hA0, 2'b11,  35, 52, 7, 5, 1'b0});
    tbl.push_back('{8'hA0, 2'b11,  35, 52, 7, 5, 1'b0});
    // release key 5 and press key 1 together
    tbl.push_back('{8'h82, 2'b11,  35, 52, 7, 5, 1'b0});
    tbl.push_back('{8'h82, 2'b01,  35, 52, 7, 5, 1'b0});
    tbl.push_back('{8'h82, 2'b11,  35, 99, 7, 1, 1'b0});

    #3 rst = 1'b0;
    #1 check("reset_state", dut_vec(), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[n]) begin
      @(negedge clk);
      key_down = tbl[n].kd;
      tick();
      check($sformatf("vec%0d", n), dut_vec(),
            pack_exp(tbl[n].ena, tbl[n].p0, tbl[n].p1, tbl[n].k0, tbl[n].k1, tbl[n].st));
    end

    // Async reset mid-hold, then keys still held are re-seen as presses.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("mid_async_rst", dut_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
    check("post_rst_e1", dut_vec(), pack_exp(2'b00, 0, 0, 0, 0, 1'b0));
    tick();
    check("post_rst_e2", dut_vec(), pack_exp(2'b01, 99, 0, 1, 0, 1'b0));
    tick();
    check("post_rst_e3", dut_vec(), pack_exp(2'b11, 99, 35, 1, 7, 1'b0));

    // Randomized phase against the model.
    @(negedge clk);
    rst = 1'b0;
    key_down = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 700 == 350) begin
        rst = 1'b0;
        #1 check("rand_async_rst", dut_vec(), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      key_down    = key_down ^ 8'($urandom & $urandom & $urandom);
      key_pitches = {$urandom, $urandom, $urandom};
      tick();
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice allocator between the debounced key inputs and the channel instances. It tracks up to NUM_KEYS note keys and assigns each pressed key to a free synth channel ("voice"), driving that channel's pitch and enable. When every voice is busy it steals the oldest voice. Outputs connect directly to the channel pitch/ena inputs ahead of wave_adder.

Parameters:
NUM_KEYS, 8, number of key requesters (2..16)
NUM_VOICES, 2, number of channels managed (2..4)
PITCH_W, 12, width of a channel pitch word

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low (asserted at 0)
key_down  input  NUM_KEYS  debounced key levels, 1 = held
key_pitches  input  NUM_KEYS*PITCH_W  pitch word per key; key i at bits [i*PITCH_W +: PITCH_W]
voice_pitch  output  NUM_VOICES*PITCH_W  registered pitch per voice, same packing
voice_ena  output  NUM_VOICES  registered enable per voice, to channel ena
voice_key  output  NUM_VOICES*4  key index owning each voice (debug/LEDs)
steal_pulse  output  1  one-cycle pulse when a busy voice is reassigned

Behaviour:
- Reset (rst=0, async): voice_ena=0, voice_pitch=0, voice_key=0, steal_pulse=0; key_prev=0; press_pend=0; rel_pend=0; age ranks = voice index (voice 0 oldest).
- Keys held while rst deasserts are seen as new presses (key_prev resets to 0).
- Edge detect, every cycle: key_prev<=key_down; press=key_down&~key_prev; release=~key_down&key_prev.
- Pending vectors: press edge sets press_pend[i]. On a release edge: if press_pend[i] is still set, clear press_pend[i] and leave rel_pend[i] clear (press never sounds); otherwise set rel_pend[i].
- Service: at most one event per cycle. Releases take priority over presses. Lowest key index is served first within each class. The serviced pending bit clears the same edge the voice registers update.
- Release service: the voice with voice_ena=1 and voice_key=i gets voice_ena<=0. voice_pitch and voice_key hold their values. If no voice owns key i (it was stolen), drop the event with no output change.
- Press service: pick the lowest-index voice with voice_ena=0. If none, pick the voice whose age rank is 0 (oldest) and assert steal_pulse for that cycle. The chosen voice gets voice_ena<=1, voice_pitch<=key_pitches[i] (captured once, not tracked afterwards) and voice_key<=i.
- Age ranks: 0..NUM_VOICES-1 form a permutation, with NUM_VOICES-1 the newest. On allocation the chosen voice takes NUM_VOICES-1 and every voice with a higher old rank decrements by 1. Releases do not change ranks.
- Latency: a key_down rise sampled at edge E1 sets press_pend at E1. Outputs change at E2 if no higher-priority event is pending, otherwise one cycle later per queued event. Release latency is identical.
- A voice_pitch change and a voice_ena rise on the same voice occur on the same edge. There is no glitch cycle with stale pitch.
- Steal of a voice already enabled: voice_ena stays 1, and pitch and key switch on the same edge.
- rst asserted mid-operation: all outputs go to reset values immediately and all pending events are discarded.

Test Plan:
- Reset, then key_down[2]=1 with key_pitches[2]=178 -> two edges later voice_ena=01, voice_pitch[0]=178, voice_key[0]=2, steal_pulse=0.
- Keys 3 (pitch 44) and 5 (pitch 52) rise in the same cycle -> voice0=44 at E2, voice1=52 at E3, voice_ena=11.
- Hold keys 3 and 5, then press key 7 (pitch 35) -> voice0 (oldest) becomes pitch 35, key 7; steal_pulse high for exactly one cycle; voice_ena stays 11. Release key 3 -> no output change.
- key_down[4] high for exactly one cycle while a release of another key is pending -> key 4 is never allocated; no voice change and no steal.
- Release key 5 and press key 1 in the same cycle -> release served first (voice1 ena=0), then key 1 takes voice1 the next cycle; no steal.
- Assert rst mid-hold with voice_ena=11 -> outputs zero asynchronously. Deassert rst with key 1 still held -> key 1 is reallocated to voice0 two edges later.
